ssd_scan_mux: RTL

Time-multiplexing scanner for a 4-digit common-anode seven-segment display. It latches a 16-bit packed BCD value and steps through the digits at a programmable refresh rate. Each step presents one 4-bit BCD nibble to the downstream BCD-to-segment decoder and drives the matching active-low anode enable. The latched value only updates at frame boundaries, so the display never tears. Leading zeros and invalid BCD digits are blanked.

---
 rtl/ssd_scan_mux.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexing scanner for a 4-digit common-anode
// seven-segment display.
//
// A 16-bit packed BCD value is captured into a shadow register on `load`.
// At each frame boundary, the shadow value is transferred to the display
// register, so a frame is never torn. A prescaler produces one tick every
// REFRESH_DIV cycles. Each tick registers the BCD nibble and the active-low
// anode enable for the current slot, and then advances the slot index.
// Leading zeros (when enabled) and non-BCD nibbles are blanked.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   load      in   single-cycle strobe, captures `value` into the shadow
//   value     in   [15:0] packed BCD, [3:0] = digit 0
//   blank_lz  in   blank leading-zero digits 3..1 (sampled on ticks)
//   digit     out  [3:0] BCD nibble for the segment decoder
//   an        out  [3:0] active-low anode enables, an[i] lights digit i
//   pending   out  loaded value waiting for the next frame boundary
//   bcd_err   out  one-cycle pulse after a load containing a nibble > 9
module ssd_scan_mux #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        pending,
  output logic        bcd_err
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_q,     cnt_d;
  logic [1:0]    idx_q,     idx_d;
  logic [15:0]   shadow_q,  shadow_d;
  logic [15:0]   disp_q,    disp_d;
  logic          pending_q, pending_d;
  logic          bcd_err_q, bcd_err_d;
  logic [3:0]    digit_q,   digit_d;
  logic [3:0]    an_q,      an_d;

  logic          tick;
  logic [15:0]   disp_src;
  logic [3:0]    nib;
  logic [15:0]   upper;
  logic          lz_blank;
  logic          val_bad;

  assign tick = (cnt_q == CW'(REFRESH_DIV - 1));

  // Any nibble of the incoming value outside 0..9.
  always_comb begin
    val_bad = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (value[i*4 +: 4] > 4'd9) val_bad = 1'b1;
    end
  end

  // On a frame-boundary swap, the slot-0 output has to see the new display
  // value in the same tick, so the output path reads the next-state source.
  always_comb begin
    disp_src = disp_q;
    if (tick && (idx_q == 2'd0) && pending_q) disp_src = shadow_q;
  end

  assign nib      = disp_src[{idx_q, 2'b00} +: 4];
  assign upper    = disp_src >> {idx_q, 2'b00};
  assign lz_blank = blank_lz && (idx_q != 2'd0) && (upper == 16'h0000);

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    bcd_err_d = 1'b0;
    digit_d   = digit_q;
    an_d      = an_q;

    if (tick) begin
      if ((idx_q == 2'd0) && pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
      if ((nib > 4'd9) || lz_blank) begin
        an_d    = '1;
        digit_d = '0;
      end else begin
        an_d    = ~(4'b0001 << idx_q);
        digit_d = nib;
      end
      idx_d = idx_q + 2'd1;
    end

    // A load in the same cycle as a swap overrides the pending clear: the
    // display takes the old shadow, and the new value waits a frame.
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
      bcd_err_d = val_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      bcd_err_q <= 1'b0;
      digit_q   <= '0;
      an_q      <= '1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      bcd_err_q <= bcd_err_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
    end
  end

  assign digit   = digit_q;
  assign an      = an_q;
  assign pending = pending_q;
  assign bcd_err = bcd_err_q;

endmodule
